// File: rtl/muxn_rr.sv
// muxn_rr: N-channel registered stream mux with a one-entry output register.
// `define MUXN_RR_EN selects round-robin arbitration; default build is fixed priority.
module muxn_rr #(
  parameter int WIDTH = 8,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SELW-1:0]  sel_q, sel_d;

  logic [NCH-1:0]   grant;
  logic [SELW-1:0]  gidx;
  logic             can_load;
  logic             xfer;

`ifdef MUXN_RR_EN
  logic [SELW-1:0]  last_q, last_d;

  // Search begins one past the last winner and wraps at NCH, not at 2^SELW.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!found && in_valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = SELW'(idx);
      end
    end
  end

  always_comb begin
    last_d = xfer ? gidx : last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= SELW'(NCH - 1);
    else        last_q <= last_d;
  end
`else
  always_comb begin
    logic found;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!found && in_valid[i]) begin
        found    = 1'b1;
        grant[i] = 1'b1;
        gidx     = SELW'(i);
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    case (state_q)
      EMPTY:   if (xfer) state_d = FULL;
      FULL:    if (xfer) state_d = FULL;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
    if (xfer) begin
      sel_d = gidx;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (grant[i]) data_d = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    out_valid = (state_q == FULL);
    can_load  = !out_valid || out_ready;
    in_ready  = grant & {NCH{can_load & rst_n}};
    xfer      = |in_ready;
    out_data  = data_q;
    out_sel   = sel_q;
  end

endmodule

// File: tb/tb_muxn_rr.sv
module tb_muxn_rr;

  logic        clk;
  logic        rst_n;

  logic [3:0]  a_in_valid, a_in_ready;
  logic [31:0] a_in_data;
  logic        a_out_valid, a_out_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_sel;

  logic [2:0]  b_in_valid, b_in_ready;
  logic [23:0] b_in_data;
  logic        b_out_valid, b_out_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_sel;

  int n_chk;
  int n_bad;

  muxn_rr #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data),
    .out_sel   (a_out_sel)
  );

  muxn_rr #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data),
    .out_sel   (b_out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

`ifdef MUXN_RR_EN
  int unsigned stream_sel [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
  int unsigned rel_sel        = 3;
  int unsigned b_sel [3]      = '{0, 2, 0};
`else
  int unsigned stream_sel [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int unsigned rel_sel        = 0;
  int unsigned b_sel [3]      = '{0, 0, 0};
`endif

  initial begin
    logic [7:0] dv [4];
    n_chk = 0;
    n_bad = 0;
    rst_n       = 1'b0;
    a_in_valid  = 4'b1111;
    a_in_data   = 32'h13121110;
    a_out_ready = 1'b1;
    b_in_valid  = 3'b111;
    b_in_data   = 24'hB2B1B0;
    b_out_ready = 1'b1;

    #3;
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data",  a_out_data, 0);
    chk("rst_a_sel",   a_out_sel, 0);
    chk("rst_a_ready", a_in_ready, 0);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_ready", b_in_ready, 0);

    tick();
    tick();
    rst_n      = 1'b1;
    b_in_valid = 3'b000;
    a_in_valid = 4'b0001;
    a_in_data  = 32'h000000A5;
    #1;
    chk("first_ready", a_in_ready, 4'b0001);
    tick();
    chk("first_valid", a_out_valid, 1);
    chk("first_data",  a_out_data, 8'hA5);
    chk("first_sel",   a_out_sel, 0);

    // all four requesting, consumer always ready
    a_in_valid = 4'b1111;
    a_in_data  = 32'h13121110;
    dv = '{8'h10, 8'h11, 8'h12, 8'h13};
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("stream_ready", a_in_ready, 32'(1) << stream_sel[k]);
      tick();
      chk("stream_valid", a_out_valid, 1);
      chk("stream_sel",   a_out_sel, stream_sel[k]);
      chk("stream_data",  a_out_data, dv[stream_sel[k]]);
    end

    // load 3C from ch2, then stall for 5 cycles
    a_in_valid = 4'b0100;
    a_in_data  = 32'h133C1110;
    #1;
    chk("ch2_ready", a_in_ready, 4'b0100);
    tick();
    chk("ch2_data", a_out_data, 8'h3C);
    chk("ch2_sel",  a_out_sel, 2);
    a_out_ready = 1'b0;
    a_in_valid  = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) a_in_valid = 4'b1111;
      #1;
      chk("hold_ready", a_in_ready, 0);
      tick();
      chk("hold_valid", a_out_valid, 1);
      chk("hold_data",  a_out_data, 8'h3C);
      chk("hold_sel",   a_out_sel, 2);
    end
    a_out_ready = 1'b1;
    dv = '{8'h10, 8'h11, 8'h3C, 8'h13};
    #1;
    chk("resume_ready", a_in_ready, 32'(1) << rel_sel);
    tick();
    chk("resume_sel",  a_out_sel, rel_sel);
    chk("resume_data", a_out_data, dv[rel_sel]);

    // drain with no requester
    a_in_valid = 4'b0000;
    #1;
    chk("idle_ready", a_in_ready, 0);
    tick();
    chk("drain_valid", a_out_valid, 0);

    // async reset while FULL
    a_in_valid = 4'b1000;
    a_in_data  = 32'h77121110;
    tick();
    chk("pre_rst_valid", a_out_valid, 1);
    chk("pre_rst_data",  a_out_data, 8'h77);
    a_in_valid  = 4'b1111;
    a_out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    a_out_ready = 1'b1;
    #1;
    chk("arst_valid", a_out_valid, 0);
    chk("arst_data",  a_out_data, 0);
    chk("arst_sel",   a_out_sel, 0);
    chk("arst_ready", a_in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", a_in_ready, 4'b0001);
    tick();
    chk("post_rst_sel",  a_out_sel, 0);
    chk("post_rst_data", a_out_data, 8'h10);
    a_in_valid = 4'b0000;

    // NCH=3: only ch0 and ch2 requesting, pointer starts at 2
    b_in_valid = 3'b101;
    dv = '{8'hB0, 8'hB1, 8'hB2, 8'h00};
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("n3_ready", b_in_ready, 32'(1) << b_sel[k]);
      tick();
      chk("n3_valid", b_out_valid, 1);
      chk("n3_sel",   b_out_sel, b_sel[k]);
      chk("n3_data",  b_out_data, dv[b_sel[k]]);
    end
    b_in_valid = 3'b000;
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
